// File: rtl/music_sequencer.sv
// ROM-driven note sequencer: walks an address window, waits out the ROM read latency,
// then holds each note for a tempo-scaled beat with a trailing articulation gap.
module music_sequencer #(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_250_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       play,
  input  logic       stop,
  input  logic       pause,
  input  logic       loop_en,
  input  logic [1:0] tempo,
  input  logic [7:0] start_addr,
  input  logic [7:0] end_addr,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_note,
  output logic [5:0] note,
  output logic       gate,
  output logic       busy,
  output logic       done
);

  // Eight spare bits so the x8 tempo shift can never overflow the counter.
  localparam int CW = $clog2(BEAT_CYCLES) + 8;
  localparam logic [CW-1:0] BEAT_BASE = CW'(BEAT_CYCLES);
  localparam logic [CW-1:0] GAP_BASE  = CW'(GAP_CYCLES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    start_q, start_d;
  logic [7:0]    end_q, end_d;
  logic [5:0]    note_q, note_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    tempo_q, tempo_d;
  logic          done_q, done_d;

  logic [CW-1:0] beat;
  logic [CW-1:0] gate_limit;
  logic          beat_end;
  logic          unused_note_hi;

  assign beat           = BEAT_BASE << tempo_q;
  assign gate_limit     = beat - GAP_BASE;
  assign beat_end       = (cnt_q == beat - CW'(1));
  assign unused_note_hi = ^rom_note[7:6];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    start_d = start_q;
    end_d   = end_q;
    note_d  = note_q;
    cnt_d   = cnt_q;
    tempo_d = tempo_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      note_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (play) begin
            start_d = start_addr;
            end_d   = end_addr;
            addr_d  = start_addr;
            state_d = S_FETCH;
          end
        end
        S_FETCH: state_d = S_LATCH;
        S_LATCH: begin
          note_d  = rom_note[5:0];
          cnt_d   = '0;
          tempo_d = tempo;
          state_d = S_HOLD;
        end
        S_HOLD: begin
          if (!pause) begin
            if (beat_end) begin
              if (addr_q != end_q) begin
                addr_d  = addr_q + 8'd1;
                state_d = S_FETCH;
              end else if (loop_en) begin
                addr_d  = start_q;
                state_d = S_FETCH;
              end else begin
                state_d = S_IDLE;
                note_d  = '0;
                done_d  = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      start_q <= '0;
      end_q   <= '0;
      note_q  <= '0;
      cnt_q   <= '0;
      tempo_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      start_q <= start_d;
      end_q   <= end_d;
      note_q  <= note_d;
      cnt_q   <= cnt_d;
      tempo_q <= tempo_d;
      done_q  <= done_d;
    end
  end

  // Gate is the only combinational output so pause silences the note immediately.
  assign gate     = (state_q == S_HOLD) && (note_q != 6'd0) && !pause && (cnt_q < gate_limit);
  assign busy     = (state_q != S_IDLE);
  assign rom_addr = addr_q;
  assign note     = note_q;
  assign done     = done_q;

endmodule
